micro_mem: RTL and testbench
============================

# micro_mem

Memory responder for the `micro` accumulator CPU: a 64×8 RAM that answers the CPU's `mem_addr`/`mem_read`/`mem_write` initiator port, plus a byte-stream program loader. After reset it zero-fills the array, accepts a program over a valid/ready byte stream, then releases the CPU from reset and serves its accesses. It also keeps sticky protocol-error and access-count status for the bench and debug.

## Interface
- `DEPTH`, 64, number of 8-bit words; the address is fixed at 6 bits and this value is fixed at 64.
- `CNT_W`, 8, width of the saturating access counters.

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset (0 = reset)
- `mem_addr`  in  6  CPU word address
- `mem_din`  in  8  CPU write data
- `mem_read`  in  1  CPU read strobe
- `mem_write`  in  1  CPU write strobe
- `mem_dout`  out  8  read data to CPU
- `cpu_reset`  out  1  active-high synchronous reset for the CPU
- `ld_valid`  in  1  loader byte valid
- `ld_data`  in  8  loader byte
- `ld_last`  in  1  final byte of program, qualified by `ld_valid`
- `ld_ready`  out  1  loader may transfer
- `reload`  in  1  pulse: restart clear/load sequence
- `err`  out  1  sticky: `mem_read` and `mem_write` seen in the same RUN cycle
- `rd_count`  out  CNT_W  RUN cycles with `mem_read`=1, saturating
- `wr_count`  out  CNT_W  RUN cycles with `mem_write`=1, saturating

## Operation
- States: CLEAR → LOAD → RUN. RUN → CLEAR on `reload`=1. CLEAR and LOAD ignore `reload`.
- **CLEAR**
  - Writes 0x00 to the address in `clr_addr` (6-bit) on each edge, then increments it.
  - After the edge that writes address 63, the block goes to LOAD.
  - `clr_addr` resets to 0 on every entry to CLEAR.
- **LOAD**
  - `ld_ready`=1.
  - Transfer = `ld_valid & ld_ready`. On a transfer, `ld_data` is written to `ld_addr`, then `ld_addr` increments. `ld_addr` is 6-bit and starts at 0 on LOAD entry.
  - If the transfer has `ld_last`=1, or `ld_addr`==63, the next state is RUN.
  - Locations that are not loaded keep 0x00.
- **RUN**
  - `mem_dout` = mem[`mem_addr`] combinationally. This is an asynchronous array read: the CPU captures `mem_dout` at the same edge it asserts `mem_read`.
  - `mem_write`=1 writes `mem_din` to mem[`mem_addr`] at the rising edge.
  - If `mem_read` and `mem_write` are both 1:
    - the write commits;
    - `mem_dout` shows the old contents that cycle;
    - `err` is set at that edge.
  - `rd_count`/`wr_count` increment per cycle their strobe is high and hold at all-ones.
- **Outside RUN**
  - `mem_dout`=0x00.
  - CPU strobes are ignored: no write, no count, no `err`.
- `cpu_reset` is registered: 1 in CLEAR and LOAD, 0 in RUN.
- `reload` in RUN:
  - Next state is CLEAR and `cpu_reset` returns to 1.
  - `err`, `rd_count` and `wr_count` clear.
  - A CPU write in the same cycle still commits; it is then zeroed by CLEAR.
- **Reset values** (`reset`=0, immediate and asynchronous):
  - state CLEAR, `clr_addr`=0, `ld_addr`=0;
  - `cpu_reset`=1, `ld_ready`=0, `mem_dout`=0x00;
  - `err`=0, `rd_count`=0, `wr_count`=0.
  - Array contents are not reset; CLEAR zeroes them.

## Timing
- Clear phase:
  - The first 64 rising edges after `reset` deasserts clear addresses 0..63.
  - `ld_ready` goes to 1 after the 64th edge.
- Load throughput is one byte per cycle. `ld_ready` does not depend combinationally on `ld_valid`.
- The edge accepting the final byte moves state to RUN. After that edge, `cpu_reset`=0 and `ld_ready`=0.
- The CPU's first un-reset edge is the next edge.
- Read latency is 0 cycles, combinational from `mem_addr`.
- Write latency is 1 edge: data is visible on `mem_dout` immediately after the write edge.
- `reload` is sampled at the edge. After that edge the block is in CLEAR with `cpu_reset`=1, and 64 more edges follow before `ld_ready`=1.
- Reset asserted mid-CLEAR, mid-LOAD or mid-RUN:
  - outputs go to their reset values without waiting for `clk`;
  - the sequence restarts from address 0.

## Test plan
- **Reset release:** `cpu_reset`=1 and `ld_ready`=0 for exactly 64 edges, then `ld_ready`=1. Any `mem_addr` during this time → `mem_dout`=0x00.
- **Short program:** load 0x05, 0x46, 0x87, with `ld_last` on the third byte.
  - `cpu_reset` falls after the third accepted edge.
  - `mem_addr`=1 → 0x46; `mem_addr`=3 → 0x00.
- **Gapped full load:** 64 bytes with `ld_valid` toggled every other cycle and `ld_last` never set → RUN entered after the 64th transfer. Every address reads back its loaded byte.
- **CPU write/read:** write 0xA5 to address 0x3F, then read 0x3F → `mem_dout`=0xA5 on the cycle after the write. `wr_count`=1, `rd_count`=1. Counts saturate at 0xFF after 300 reads.
- **Collision:** address 2 holds 0x11; `mem_read`=`mem_write`=1 with `mem_din`=0x22.
  - `mem_dout`=0x11 in that cycle.
  - `err`=1 afterwards and stays 1.
  - A later read of address 2 → 0x22.
  - A `reload` pulse clears `err`.
- **Reset mid-LOAD:** after 5 bytes are loaded, pulse `reset` low → `cpu_reset`=1 and `ld_ready`=0 immediately. After release, a full 64-edge clear runs and address 0 reads 0x00.

Source files
------------

// File: rtl/micro_mem_if.sv
// micro_mem_if: bus bundle between the micro CPU / program loader side and the
// micro_mem responder.
//   CPU port    : mem_addr, mem_din, mem_read, mem_write -> mem_dout, cpu_reset
//   Loader port : ld_valid, ld_data, ld_last             -> ld_ready
//   Control     : reload
//   Status      : err, rd_count, wr_count (CNT_W-bit saturating counters)
// Modports: master = CPU/loader/bench side, slave = memory responder.
interface micro_mem_if #(
  parameter int CNT_W = 8
);
  logic [5:0]       mem_addr;
  logic [7:0]       mem_din;
  logic             mem_read;
  logic             mem_write;
  logic [7:0]       mem_dout;
  logic             cpu_reset;
  logic             ld_valid;
  logic [7:0]       ld_data;
  logic             ld_last;
  logic             ld_ready;
  logic             reload;
  logic             err;
  logic [CNT_W-1:0] rd_count;
  logic [CNT_W-1:0] wr_count;

  modport master (
    output mem_addr, mem_din, mem_read, mem_write, ld_valid, ld_data, ld_last, reload,
    input  mem_dout, cpu_reset, ld_ready, err, rd_count, wr_count
  );

  modport slave (
    input  mem_addr, mem_din, mem_read, mem_write, ld_valid, ld_data, ld_last, reload,
    output mem_dout, cpu_reset, ld_ready, err, rd_count, wr_count
  );
endinterface

// File: rtl/micro_mem.sv
// micro_mem: 64x8 RAM responder for the micro accumulator CPU with a
// byte-stream program loader.
// Sequence: CLEAR (zero-fill all 64 words) -> LOAD (accept bytes over
// valid/ready) -> RUN (serve CPU reads/writes). A reload pulse in RUN restarts
// the sequence. The CPU is held in reset (cpu_reset=1) until RUN.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset
//   bus   - micro_mem_if slave modport (CPU port, loader stream, status)
module micro_mem #(
  parameter int DEPTH = 64,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  micro_mem_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  localparam logic [5:0] LAST_ADDR = 6'(DEPTH - 1);

  state_t           r_state;
  logic [5:0]       r_clr_addr;
  logic [5:0]       r_ld_addr;
  logic             r_cpu_reset;
  logic             r_ld_ready;
  logic             r_err;
  logic [CNT_W-1:0] r_rd_count;
  logic [CNT_W-1:0] r_wr_count;
  logic [7:0]       r_mem [DEPTH];

  logic             w_xfer;
  logic             w_we;
  logic [5:0]       w_waddr;
  logic [7:0]       w_wdata;

  // r_ld_ready is high exactly while in LOAD, so it doubles as the state qualifier.
  assign w_xfer = bus.ld_valid & r_ld_ready;

  // Single write port shared by the clear sweep, the loader and the CPU.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = bus.mem_addr;
    w_wdata = bus.mem_din;
    case (r_state)
      ST_CLEAR: begin
        w_we    = 1'b1;
        w_waddr = r_clr_addr;
        w_wdata = 8'h00;
      end
      ST_LOAD: begin
        w_we    = w_xfer;
        w_waddr = r_ld_addr;
        w_wdata = bus.ld_data;
      end
      ST_RUN:  w_we = bus.mem_write;
      default: w_we = 1'b0;
    endcase
  end

  // NOTE: the array has no reset; the CLEAR sweep zeroes it after every reset.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  // Asynchronous read: on a read/write collision this shows the old contents,
  // because the write only lands at the edge.
  assign bus.mem_dout = (r_state == ST_RUN) ? r_mem[bus.mem_addr] : 8'h00;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_CLEAR;
      r_clr_addr  <= '0;
      r_ld_addr   <= '0;
      r_cpu_reset <= 1'b1;
      r_ld_ready  <= 1'b0;
      r_err       <= 1'b0;
      r_rd_count  <= '0;
      r_wr_count  <= '0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_clr_addr <= r_clr_addr + 6'd1;
          if (r_clr_addr == LAST_ADDR) begin
            r_state    <= ST_LOAD;
            r_ld_addr  <= '0;
            r_ld_ready <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (w_xfer) begin
            r_ld_addr <= r_ld_addr + 6'd1;
            if (bus.ld_last || (r_ld_addr == LAST_ADDR)) begin
              r_state     <= ST_RUN;
              r_cpu_reset <= 1'b0;
              r_ld_ready  <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          if (bus.reload) begin
            // Status clears on reload; any same-cycle CPU write still lands
            // and is then wiped by the clear sweep.
            r_state     <= ST_CLEAR;
            r_clr_addr  <= '0;
            r_cpu_reset <= 1'b1;
            r_err       <= 1'b0;
            r_rd_count  <= '0;
            r_wr_count  <= '0;
          end else begin
            if (bus.mem_read && bus.mem_write) r_err <= 1'b1;
            if (bus.mem_read && (r_rd_count != '1)) r_rd_count <= r_rd_count + 1'b1;
            if (bus.mem_write && (r_wr_count != '1)) r_wr_count <= r_wr_count + 1'b1;
          end
        end
        default: begin
          r_state     <= ST_CLEAR;
          r_clr_addr  <= '0;
          r_cpu_reset <= 1'b1;
          r_ld_ready  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cpu_reset = r_cpu_reset;
  assign bus.ld_ready  = r_ld_ready;
  assign bus.err       = r_err;
  assign bus.rd_count  = r_rd_count;
  assign bus.wr_count  = r_wr_count;

endmodule

// File: tb/tb_micro_mem.sv
// tb_micro_mem: directed stimulus with a queue-based scoreboard. Stimulus
// drives inputs shortly after a rising edge and pushes the expected output
// values; the monitor pops and compares them at the following falling edge.
module tb_micro_mem;

  typedef enum int {S_DOUT, S_CPURST, S_LDRDY, S_ERR, S_RDC, S_WRC} sel_t;

  typedef struct {
    string      name;
    sel_t       sel;
    logic [7:0] exp;
  } exp_t;

  logic clk;
  logic reset;
  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  micro_mem_if #(.CNT_W(8)) u_if ();

  micro_mem #(.DEPTH(64), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] sample(input sel_t s);
    case (s)
      S_DOUT:   return u_if.mem_dout;
      S_CPURST: return {7'd0, u_if.cpu_reset};
      S_LDRDY:  return {7'd0, u_if.ld_ready};
      S_ERR:    return {7'd0, u_if.err};
      S_RDC:    return u_if.rd_count;
      S_WRC:    return u_if.wr_count;
      default:  return 8'hxx;
    endcase
  endfunction

  task automatic push(input string name, input sel_t s, input logic [7:0] v);
    exp_t e;
    e.name = name;
    e.sel  = s;
    e.exp  = v;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Gapped-load byte pattern: 0xFF, 0xFC, 0xF9, ... distinct per address.
  function automatic logic [7:0] gbyte(input int i);
    return 8'(255 - 3 * i);
  endfunction

  // Monitor: compare everything queued at the falling edge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check(e.name, sample(e.sel), e.exp);
    end
  end

  initial begin
    reset          = 1'b0;
    u_if.mem_addr  = '0;
    u_if.mem_din   = '0;
    u_if.mem_read  = 1'b0;
    u_if.mem_write = 1'b0;
    u_if.ld_valid  = 1'b0;
    u_if.ld_data   = '0;
    u_if.ld_last   = 1'b0;
    u_if.reload    = 1'b0;

    // Reset state
    #1;
    push("rst_cpu_reset", S_CPURST, 8'h01);
    push("rst_ld_ready",  S_LDRDY,  8'h00);
    push("rst_dout",      S_DOUT,   8'h00);
    push("rst_err",       S_ERR,    8'h00);
    push("rst_rd_count",  S_RDC,    8'h00);
    push("rst_wr_count",  S_WRC,    8'h00);
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Reset release: 64 clear edges with the CPU held and the loader stalled
    for (int i = 0; i < 64; i++) begin
      u_if.mem_addr = 6'(i);
      u_if.mem_read = 1'b1;
      push($sformatf("clr_ld_ready[%0d]", i), S_LDRDY,  8'h00);
      push($sformatf("clr_cpu_reset[%0d]", i), S_CPURST, 8'h01);
      push($sformatf("clr_dout[%0d]", i),      S_DOUT,   8'h00);
      tick();
    end
    u_if.mem_read = 1'b0;
    push("clr_done_ld_ready",  S_LDRDY,  8'h01);
    push("clr_done_cpu_reset", S_CPURST, 8'h01);

    // Short program: 0x05, 0x46, 0x87 with ld_last on the third byte
    u_if.ld_valid = 1'b1;
    u_if.ld_data  = 8'h05;
    tick();
    u_if.ld_data  = 8'h46;
    tick();
    u_if.ld_data  = 8'h87;
    u_if.ld_last  = 1'b1;
    push("short_pre_cpu_reset", S_CPURST, 8'h01);
    push("short_pre_ld_ready",  S_LDRDY,  8'h01);
    tick();
    u_if.ld_valid = 1'b0;
    u_if.ld_last  = 1'b0;
    push("short_run_cpu_reset", S_CPURST, 8'h00);
    push("short_run_ld_ready",  S_LDRDY,  8'h00);
    u_if.mem_addr = 6'd1;  push("short_rd1",  S_DOUT, 8'h46); tick();
    u_if.mem_addr = 6'd0;  push("short_rd0",  S_DOUT, 8'h05); tick();
    u_if.mem_addr = 6'd2;  push("short_rd2",  S_DOUT, 8'h87); tick();
    u_if.mem_addr = 6'd3;  push("short_rd3",  S_DOUT, 8'h00); tick();
    u_if.mem_addr = 6'd63; push("short_rd63", S_DOUT, 8'h00); tick();

    // CPU write then read of the top address
    u_if.mem_addr  = 6'h3F;
    u_if.mem_din   = 8'hA5;
    u_if.mem_write = 1'b1;
    tick();
    u_if.mem_write = 1'b0;
    u_if.mem_read  = 1'b1;
    push("wr_rd_3f", S_DOUT, 8'hA5);
    tick();
    u_if.mem_read = 1'b0;
    push("wr_count_1", S_WRC, 8'h01);
    push("rd_count_1", S_RDC, 8'h01);
    push("err_clean",  S_ERR, 8'h00);

    // Read-counter saturation: 300 more reads
    u_if.mem_read = 1'b1;
    repeat (253) tick();
    push("rd_count_fe", S_RDC, 8'hFE);
    tick();
    push("rd_count_ff", S_RDC, 8'hFF);
    repeat (46) tick();
    u_if.mem_read = 1'b0;
    push("rd_count_sat", S_RDC, 8'hFF);
    push("wr_count_hold", S_WRC, 8'h01);

    // Collision at address 2 (seeded with 0x11)
    u_if.mem_addr  = 6'd2;
    u_if.mem_din   = 8'h11;
    u_if.mem_write = 1'b1;
    tick();
    push("seed_wr_count", S_WRC, 8'h02);
    u_if.mem_read  = 1'b1;
    u_if.mem_din   = 8'h22;
    push("coll_dout_old", S_DOUT, 8'h11);
    push("coll_err_pre",  S_ERR,  8'h00);
    tick();
    u_if.mem_read  = 1'b0;
    u_if.mem_write = 1'b0;
    push("coll_err_set",  S_ERR, 8'h01);
    push("coll_wr_count", S_WRC, 8'h03);
    tick();
    u_if.mem_read = 1'b1;
    push("coll_new_data", S_DOUT, 8'h22);
    tick();
    u_if.mem_read = 1'b0;
    push("coll_err_sticky", S_ERR, 8'h01);

    // Reload with a same-cycle CPU write
    u_if.reload    = 1'b1;
    u_if.mem_write = 1'b1;
    u_if.mem_addr  = 6'd5;
    u_if.mem_din   = 8'h77;
    tick();
    u_if.reload    = 1'b0;
    u_if.mem_write = 1'b0;
    push("reload_cpu_reset", S_CPURST, 8'h01);
    push("reload_ld_ready",  S_LDRDY,  8'h00);
    push("reload_err",       S_ERR,    8'h00);
    push("reload_rd_count",  S_RDC,    8'h00);
    push("reload_wr_count",  S_WRC,    8'h00);
    push("reload_dout",      S_DOUT,   8'h00);
    repeat (63) tick();
    push("reload_clr63_ld_ready", S_LDRDY, 8'h00);
    tick();
    push("reload_clr64_ld_ready", S_LDRDY, 8'h01);

    // Gapped full load; CPU strobes held high must be ignored outside RUN
    u_if.mem_read  = 1'b1;
    u_if.mem_write = 1'b1;
    u_if.mem_addr  = 6'd10;
    u_if.mem_din   = 8'hFF;
    for (int i = 0; i < 64; i++) begin
      u_if.ld_valid = 1'b1;
      u_if.ld_data  = gbyte(i);
      if (i == 32) push("gap_mid_ld_ready", S_LDRDY, 8'h01);
      if (i == 63) push("gap_pre_cpu_reset", S_CPURST, 8'h01);
      tick();
      u_if.ld_valid = 1'b0;
      if (i == 63) begin
        u_if.mem_read  = 1'b0;
        u_if.mem_write = 1'b0;
      end else begin
        tick();
      end
    end
    push("gap_run_cpu_reset", S_CPURST, 8'h00);
    push("gap_run_ld_ready",  S_LDRDY,  8'h00);
    push("gap_err_ignored",   S_ERR,    8'h00);
    push("gap_rd_ignored",    S_RDC,    8'h00);
    push("gap_wr_ignored",    S_WRC,    8'h00);
    for (int i = 0; i < 64; i++) begin
      u_if.mem_addr = 6'(i);
      push($sformatf("gap_rd[%0d]", i), S_DOUT, gbyte(i));
      tick();
    end

    // Reset asserted mid-LOAD
    u_if.reload = 1'b1;
    tick();
    u_if.reload = 1'b0;
    repeat (64) tick();
    push("mid_ld_ready", S_LDRDY, 8'h01);
    for (int i = 1; i <= 5; i++) begin
      u_if.ld_valid = 1'b1;
      u_if.ld_data  = 8'(i + 1);
      tick();
    end
    u_if.ld_valid = 1'b0;
    #1;
    reset = 1'b0;
    push("async_cpu_reset", S_CPURST, 8'h01);
    push("async_ld_ready",  S_LDRDY,  8'h00);
    push("async_dout",      S_DOUT,   8'h00);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (63) tick();
    push("rerun_clr63_ld_ready",  S_LDRDY,  8'h00);
    push("rerun_clr63_cpu_reset", S_CPURST, 8'h01);
    tick();
    push("rerun_clr64_ld_ready", S_LDRDY, 8'h01);
    u_if.ld_valid = 1'b1;
    u_if.ld_last  = 1'b1;
    u_if.ld_data  = 8'hC3;
    tick();
    u_if.ld_valid = 1'b0;
    u_if.ld_last  = 1'b0;
    push("rerun_cpu_reset", S_CPURST, 8'h00);
    u_if.mem_addr = 6'd0; push("rerun_rd0", S_DOUT, 8'hC3); tick();
    u_if.mem_addr = 6'd1; push("rerun_rd1", S_DOUT, 8'h00); tick();
    u_if.mem_addr = 6'd4; push("rerun_rd4", S_DOUT, 8'h00); tick();

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
